// File: rtl/steer_cmd_mapper.sv
// Maps signed controller samples to move_cmd/speed_level with deadband hysteresis,
// saturated scaled magnitude, speed rate limiting and a track/search/halt lost-line FSM.
module steer_cmd_mapper #(
    parameter int CTRL_W         = 32,
    parameter int SPEED_W        = 4,
    parameter int DEADBAND       = 10,
    parameter int HYST           = 2,
    parameter int SHIFT          = 0,
    parameter int STRAIGHT_SPEED = 1,
    parameter int RATE_STEP      = 2,
    parameter int LOST_FRAMES    = 8,
    parameter int SEARCH_FRAMES  = 60,
    parameter int SEARCH_SPEED   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic signed [CTRL_W-1:0] ctrl_out,
    input  logic                     ctrl_valid,
    input  logic                     line_found,
    output logic [3:0]               move_cmd,
    output logic [SPEED_W-1:0]       speed_level,
    output logic                     cmd_valid,
    output logic [1:0]               state_dbg
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_TRACK  = 2'b01,
        ST_SEARCH = 2'b10,
        ST_HALT   = 2'b11
    } state_t;

    localparam int MW     = CTRL_W + 1;
    localparam int SW2    = SPEED_W + 2;
    localparam int LOST_W = $clog2(LOST_FRAMES) + 1;
    localparam int SRCH_W = $clog2(SEARCH_FRAMES) + 1;

    localparam logic [3:0] MV_W    = 4'b0000;
    localparam logic [3:0] MV_WA   = 4'b0001;
    localparam logic [3:0] MV_WD   = 4'b0010;
    localparam logic [3:0] MV_STOP = 4'b0011;

    localparam logic [MW-1:0]      SPEED_MAX_M = MW'((2 ** SPEED_W) - 1);
    localparam logic [MW-1:0]      DB_M        = MW'(DEADBAND);
    localparam logic [MW-1:0]      REL_M       = MW'(DEADBAND - HYST);
    localparam logic [SPEED_W-1:0] STRAIGHT_V  = SPEED_W'(STRAIGHT_SPEED);
    localparam logic [SPEED_W-1:0] SEARCH_V    = SPEED_W'(SEARCH_SPEED);
    localparam logic [SPEED_W-1:0] SPEED_ZERO  = {SPEED_W{1'b0}};
    localparam logic [LOST_W-1:0]  LOST_LIM    = LOST_W'(LOST_FRAMES);
    localparam logic [SRCH_W-1:0]  SRCH_LIM    = SRCH_W'(SEARCH_FRAMES);

    // Step prev toward tgt by at most RATE_STEP
    function automatic logic [SPEED_W-1:0] ramp(input logic [SPEED_W-1:0] prev,
                                                input logic [SPEED_W-1:0] tgt);
        logic [SW2-1:0] p;
        logic [SW2-1:0] t;
        logic [SW2-1:0] r;
        p = {2'b00, prev};
        t = {2'b00, tgt};
        r = SW2'(RATE_STEP);
        if (t > p + r) begin
            ramp = SPEED_W'(p + r);
        end else if (p > t + r) begin
            ramp = SPEED_W'(p - r);
        end else begin
            ramp = tgt;
        end
    endfunction

    state_t              state_r, state_s;
    logic [3:0]          move_r, move_s, last_turn_r, last_s;
    logic [SPEED_W-1:0]  speed_r, speed_s;
    logic                valid_r, valid_s;
    logic [LOST_W-1:0]   lost_cnt_r, lost_s, lost_inc_s;
    logic [SRCH_W-1:0]   search_cnt_r, search_s, search_inc_s;

    logic signed [MW-1:0] ctrl_ext_s;
    logic [MW-1:0]        mag_s, scaled_s;
    logic [SPEED_W-1:0]   tgt_s, trk_speed_s;
    logic [3:0]           trk_move_s, trk_last_s;
    logic                 turning_s;

    // TRACK mapping: magnitude, saturated target and hysteretic direction
    always_comb begin
        ctrl_ext_s = {ctrl_out[CTRL_W-1], ctrl_out};
        if (ctrl_ext_s[MW-1]) begin
            mag_s = MW'(-ctrl_ext_s);
        end else begin
            mag_s = MW'(ctrl_ext_s);
        end
        scaled_s = mag_s >> SHIFT;
        if (scaled_s > SPEED_MAX_M) begin
            tgt_s = SPEED_W'(SPEED_MAX_M);
        end else if (scaled_s == {MW{1'b0}}) begin
            tgt_s = {{(SPEED_W-1){1'b0}}, 1'b1};
        end else begin
            tgt_s = scaled_s[SPEED_W-1:0];
        end
        turning_s = (move_r == MV_WA) || (move_r == MV_WD);
        if (ctrl_ext_s > $signed(DB_M)) begin
            trk_move_s  = MV_WA;
            trk_speed_s = ramp(speed_r, tgt_s);
        end else if (ctrl_ext_s < -$signed(DB_M)) begin
            trk_move_s  = MV_WD;
            trk_speed_s = ramp(speed_r, tgt_s);
        end else if (turning_s && (mag_s > REL_M)) begin
            trk_move_s  = move_r;
            trk_speed_s = ramp(speed_r, tgt_s);
        end else begin
            trk_move_s  = MV_W;
            trk_speed_s = ramp(speed_r, STRAIGHT_V);
        end
        if (trk_move_s == MV_W) begin
            trk_last_s = last_turn_r;
        end else begin
            trk_last_s = trk_move_s;
        end
    end

    // Saturating increments of the lost-line counters
    always_comb begin
        if (lost_cnt_r == {LOST_W{1'b1}}) begin
            lost_inc_s = lost_cnt_r;
        end else begin
            lost_inc_s = lost_cnt_r + LOST_W'(1);
        end
        if (search_cnt_r == {SRCH_W{1'b1}}) begin
            search_inc_s = search_cnt_r;
        end else begin
            search_inc_s = search_cnt_r + SRCH_W'(1);
        end
    end

    // Next-state and next-output logic for the lost-line FSM
    always_comb begin
        state_s  = state_r;
        move_s   = move_r;
        speed_s  = speed_r;
        valid_s  = 1'b0;
        lost_s   = lost_cnt_r;
        search_s = search_cnt_r;
        last_s   = last_turn_r;
        if (!en) begin
            state_s  = ST_IDLE;
            move_s   = MV_STOP;
            speed_s  = SPEED_ZERO;
            lost_s   = {LOST_W{1'b0}};
            search_s = {SRCH_W{1'b0}};
        end else if (ctrl_valid) begin
            valid_s = 1'b1;
            if (line_found) begin
                // IDLE/HALT hold STOP/0, so the mapping naturally starts from 0, not turning
                state_s  = ST_TRACK;
                move_s   = trk_move_s;
                speed_s  = trk_speed_s;
                last_s   = trk_last_s;
                lost_s   = {LOST_W{1'b0}};
                search_s = {SRCH_W{1'b0}};
            end else begin
                case (state_r)
                    ST_TRACK: begin
                        lost_s = lost_inc_s;
                        if (lost_inc_s == LOST_LIM) begin
                            state_s  = ST_SEARCH;
                            move_s   = last_turn_r;
                            speed_s  = ramp(speed_r, SEARCH_V);
                            search_s = {SRCH_W{1'b0}};
                        end else begin
                            state_s = ST_TRACK;
                        end
                    end
                    ST_SEARCH: begin
                        search_s = search_inc_s;
                        if (search_inc_s == SRCH_LIM) begin
                            state_s = ST_HALT;
                            move_s  = MV_STOP;
                            speed_s = SPEED_ZERO;
                        end else begin
                            move_s  = last_turn_r;
                            speed_s = ramp(speed_r, SEARCH_V);
                        end
                    end
                    ST_HALT: begin
                        move_s  = MV_STOP;
                        speed_s = SPEED_ZERO;
                    end
                    default: begin
                        state_s = ST_IDLE;
                        move_s  = MV_STOP;
                        speed_s = SPEED_ZERO;
                    end
                endcase
            end
        end else begin
            valid_s = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            move_r       <= MV_STOP;
            speed_r      <= SPEED_ZERO;
            valid_r      <= 1'b0;
            lost_cnt_r   <= {LOST_W{1'b0}};
            search_cnt_r <= {SRCH_W{1'b0}};
            last_turn_r  <= MV_WA;
        end else begin
            state_r      <= state_s;
            move_r       <= move_s;
            speed_r      <= speed_s;
            valid_r      <= valid_s;
            lost_cnt_r   <= lost_s;
            search_cnt_r <= search_s;
            last_turn_r  <= last_s;
        end
    end

    assign move_cmd    = move_r;
    assign speed_level = speed_r;
    assign cmd_valid   = valid_r;
    assign state_dbg   = state_r;

endmodule

// File: tb/tb_steer_cmd_mapper.sv
// Self-checking bench for steer_cmd_mapper: directed plan steps pinned to literals,
// then randomized traffic compared every cycle against a behavioural model.
module tb_steer_cmd_mapper;
    localparam int DB       = 10;
    localparam int HY       = 2;
    localparam int SH       = 0;
    localparam int SMAX     = 15;
    localparam int STRAIGHT = 1;
    localparam int RS       = 2;
    localparam int LOSTN    = 8;
    localparam int SRCHN    = 60;
    localparam int SRCH_SPD = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               en;
    logic signed [31:0] ctrl_out;
    logic               ctrl_valid;
    logic               line_found;
    logic [3:0]         move_cmd;
    logic [3:0]         speed_level;
    logic               cmd_valid;
    logic [1:0]         state_dbg;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_on  = 1'b0;

    // model state: st 0 IDLE,1 TRACK,2 SEARCH,3 HALT; mv 0 W,1 WA,2 WD,3 STOP
    int m_st, m_mv, m_sp, m_lost, m_srch, m_last;
    bit m_cv;

    always #5 clk = ~clk;

    steer_cmd_mapper dut (
        .clk(clk), .reset(reset), .en(en), .ctrl_out(ctrl_out),
        .ctrl_valid(ctrl_valid), .line_found(line_found),
        .move_cmd(move_cmd), .speed_level(speed_level),
        .cmd_valid(cmd_valid), .state_dbg(state_dbg)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    endtask

    task automatic pin(input string n, input int mv, input int sp, input int st, input int cv);
        chk({n, ".move"}, int'(move_cmd), mv);
        chk({n, ".speed"}, int'(speed_level), sp);
        chk({n, ".state"}, int'(state_dbg), st);
        chk({n, ".valid"}, int'(cmd_valid), cv);
    endtask

    function automatic int toward(input int prev, input int tgt);
        int d;
        d = tgt - prev;
        if (d > RS) d = RS;
        if (d < -RS) d = -RS;
        return prev + d;
    endfunction

    task automatic model_step(input bit e, input bit v, input bit lf, input longint c);
        longint mag, t;
        int     mv;
        if (!e) begin
            m_st = 0; m_mv = 3; m_sp = 0; m_lost = 0; m_srch = 0; m_cv = 1'b0;
        end else if (!v) begin
            m_cv = 1'b0;
        end else begin
            m_cv = 1'b1;
            if (lf) begin
                mag = (c < 0) ? -c : c;
                t = mag >> SH;
                if (t > SMAX) t = SMAX;
                if (t < 1) t = 1;
                if (c > DB) mv = 1;
                else if (c < -DB) mv = 2;
                else if ((m_mv == 1 || m_mv == 2) && mag > DB - HY) mv = m_mv;
                else begin mv = 0; t = STRAIGHT; end
                m_sp = toward((m_st == 0 || m_st == 3) ? 0 : m_sp, int'(t));
                m_mv = mv;
                if (mv != 0) m_last = mv;
                m_st = 1; m_lost = 0; m_srch = 0;
            end else if (m_st == 1) begin
                m_lost++;
                if (m_lost == LOSTN) begin
                    m_st = 2; m_mv = m_last; m_sp = toward(m_sp, SRCH_SPD); m_srch = 0;
                end
            end else if (m_st == 2) begin
                m_srch++;
                if (m_srch == SRCHN) begin
                    m_st = 3; m_mv = 3; m_sp = 0;
                end else begin
                    m_sp = toward(m_sp, SRCH_SPD);
                end
            end else begin
                m_mv = 3; m_sp = 0;
            end
        end
    endtask

    // Reference model advances on the same edges as the design
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st = 0; m_mv = 3; m_sp = 0; m_cv = 1'b0; m_lost = 0; m_srch = 0; m_last = 1;
        end else begin
            model_step(en, ctrl_valid, line_found, longint'(ctrl_out));
        end
    end

    // Per-cycle comparison on the falling edge
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc.move", int'(move_cmd), m_mv);
            chk("cyc.speed", int'(speed_level), m_sp);
            chk("cyc.valid", int'(cmd_valid), int'(m_cv));
            chk("cyc.state", int'(state_dbg), m_st);
        end
    end

    task automatic apply(input bit e, input bit v, input bit lf, input int c);
        @(posedge clk); #1;
        en = e; ctrl_valid = v; line_found = lf; ctrl_out = c;
        @(posedge clk); #1;
        ctrl_valid = 1'b0;
    endtask

    initial begin
        int c, sel, pf;
        reset = 1'b1; en = 1'b0; ctrl_valid = 1'b0; line_found = 1'b0; ctrl_out = 32'sd0;
        repeat (2) @(posedge clk);
        #1;
        pin("reset", 3, 0, 0, 0);
        chk_on = 1'b1;
        reset = 1'b0; en = 1'b1;

        repeat (3) apply(1'b1, 1'b1, 1'b1, -40);
        pin("wd6", 2, 6, 1, 1);
        #3 reset = 1'b1;
        #1 pin("async_rst", 3, 0, 0, 0);
        @(posedge clk); #1 reset = 1'b0;

        apply(1'b1, 1'b1, 1'b1, 0);
        pin("enter_track", 0, 1, 1, 1);
        repeat (5) apply(1'b1, 1'b1, 1'b1, 11);
        pin("ramp11", 1, 11, 1, 1);
        apply(1'b1, 1'b1, 1'b1, 11);
        pin("hold11", 1, 11, 1, 1);
        repeat (3) apply(1'b1, 1'b1, 1'b1, 200);
        pin("sat15", 1, 15, 1, 1);
        apply(1'b1, 1'b1, 1'b1, 9);
        pin("hyst_keep", 1, 13, 1, 1);
        apply(1'b1, 1'b1, 1'b1, 8);
        pin("hyst_rel", 0, 11, 1, 1);
        apply(1'b1, 1'b1, 1'b1, 10);
        pin("db_edge", 0, 9, 1, 1);

        apply(1'b0, 1'b1, 1'b1, 0);
        pin("en_off", 3, 0, 0, 0);
        repeat (4) apply(1'b1, 1'b1, 1'b1, 40);
        pin("wa8", 1, 8, 1, 1);
        apply(1'b1, 1'b1, 1'b1, -40);
        pin("reverse", 2, 10, 1, 1);
        apply(1'b1, 1'b1, 1'b1, int'(32'h8000_0000));
        pin("min_int", 2, 12, 1, 1);
        apply(1'b1, 1'b1, 1'b1, int'(32'h8000_0000));

        repeat (7) apply(1'b1, 1'b1, 1'b0, 0);
        pin("lost7", 2, 14, 1, 1);
        apply(1'b1, 1'b1, 1'b0, 0);
        pin("search", 2, 12, 2, 1);
        repeat (59) apply(1'b1, 1'b1, 1'b0, 0);
        pin("search59", 2, 3, 2, 1);
        apply(1'b1, 1'b1, 1'b0, 0);
        pin("halt", 3, 0, 3, 1);
        apply(1'b1, 1'b1, 1'b1, 0);
        pin("rehome", 0, 1, 1, 1);

        repeat (8) apply(1'b1, 1'b1, 1'b0, 0);
        pin("search2", 2, 3, 2, 1);
        apply(1'b0, 1'b1, 1'b0, 0);
        pin("en_wins", 3, 0, 0, 0);
        apply(1'b1, 1'b1, 1'b0, 0);
        pin("idle_lost", 3, 0, 0, 1);

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            case ((i / 300) % 4)
                0: pf = 90;
                1: pf = 20;
                2: pf = 0;
                default: pf = 60;
            endcase
            sel = int'($urandom_range(0, 9));
            if (sel == 0) c = int'(32'h8000_0000);
            else if (sel == 1) c = int'(32'h7fff_ffff);
            else if (sel <= 5) c = int'($urandom_range(0, 40)) - 20;
            else if (sel <= 7) c = int'($urandom_range(0, 600)) - 300;
            else c = int'($urandom);
            en         = ($urandom_range(0, 99) < 97);
            ctrl_valid = ($urandom_range(0, 99) < 60);
            line_found = (int'($urandom_range(0, 99)) < pf);
            ctrl_out   = c;
        end
        @(posedge clk); #1 ctrl_valid = 1'b0;
        @(negedge clk);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/steer_cmd_mapper.md
Name: steer_cmd_mapper

Overview:
Parametrised successor of the PID-output-to-motor-command stage in the line-following pipeline. It converts each signed controller sample into a move_cmd/speed_level pair. Over the fixed-threshold mapping it adds:
- deadband hysteresis
- scaled magnitude with saturation
- per-frame speed rate limiting
- a lost-line state machine (track, search, halt)

It sits between pid_controller and the UART/motor command encoder.

Parameters:
CTRL_W, 32, width of signed controller input
SPEED_W, 4, width of speed_level
DEADBAND, 10, |ctrl| above which a turn is commanded
HYST, 2, release margin; a turn drops to straight when |ctrl| <= DEADBAND-HYST
SHIFT, 0, right-shift applied to |ctrl| before saturation
STRAIGHT_SPEED, 1, speed_level while driving straight
RATE_STEP, 2, max change of speed_level per accepted update
LOST_FRAMES, 8, consecutive line-lost updates before entering SEARCH
SEARCH_FRAMES, 60, updates spent in SEARCH before HALT
SEARCH_SPEED, 3, speed_level used while searching

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
en  in  1  enable; low forces IDLE
ctrl_out  in  CTRL_W  signed controller output (two's complement)
ctrl_valid  in  1  one-cycle strobe; ctrl_out and line_found are valid this cycle
line_found  in  1  1 = line detected in the frame that produced ctrl_out
move_cmd  out  4  0000 W (forward), 0001 WA (left), 0010 WD (right), 0011 STOP
speed_level  out  SPEED_W  unsigned speed
cmd_valid  out  1  one-cycle strobe; outputs were updated
state_dbg  out  2  00 IDLE, 01 TRACK, 10 SEARCH, 11 HALT

Behaviour:
- Reset (async, any cycle): state IDLE, move_cmd STOP, speed_level 0, cmd_valid 0, lost_cnt 0, search_cnt 0, last_turn WA.
- Update rules:
  - All updates occur only on a cycle with ctrl_valid=1 and en=1.
  - Outputs register on the next edge (latency 1). cmd_valid pulses in the same cycle the outputs change.
  - Without ctrl_valid, all outputs and state hold.
- en=0: on the next edge, state IDLE, move_cmd STOP, speed 0, counters cleared. No cmd_valid pulse. ctrl_valid is ignored.
- IDLE: the first accepted update with line_found=1 enters TRACK and applies the TRACK mapping in the same update. With line_found=0, IDLE persists and cmd_valid pulses with STOP/0.
- TRACK, line_found=1 (lost_cnt cleared):
  - Magnitude: mag = |ctrl_out| computed in CTRL_W+1 bits, so the most negative value is handled.
  - Target: tgt = min(mag>>SHIFT, 2^SPEED_W-1), with a floor of 1.
  - Direction with hysteresis: ctrl_out > DEADBAND -> WA. ctrl_out < -DEADBAND -> WD. Otherwise, if currently turning and |ctrl_out| > DEADBAND-HYST, keep the current turn. Otherwise W with tgt = STRAIGHT_SPEED.
  - A direct WA<->WD reversal is allowed. last_turn records the latest WA/WD issued.
  - Rate limit: new speed = prev + clamp(tgt-prev, -RATE_STEP, +RATE_STEP). Apply the same in all states except HALT/IDLE. The first TRACK update from IDLE starts from prev=0.
- TRACK, line_found=0:
  - Increment lost_cnt and hold move_cmd/speed. cmd_valid still pulses.
  - When the incremented lost_cnt equals LOST_FRAMES, enter SEARCH: move_cmd = last_turn, speed ramps toward SEARCH_SPEED, search_cnt = 0.
- SEARCH:
  - line_found=1: enter TRACK, clear counters, apply the TRACK mapping from current speed.
  - line_found=0: increment search_cnt. When it reaches SEARCH_FRAMES, enter HALT with STOP and speed 0 (immediate, no ramp).
- HALT: STOP/0 held. A line_found=1 update enters TRACK with speed ramping from 0.
- Counters saturate and never wrap. Widths are $clog2 of the parameter plus 1.
- Simultaneous en falling and ctrl_valid: en wins.
- Async reset mid-ramp: all outputs revert to reset values immediately.

Test Plan:
- Reset asserted mid-operation with move_cmd=WD, speed=6 -> move_cmd STOP, speed 0, state IDLE without a clock edge; no cmd_valid.
- From TRACK straight (defaults), ctrl=+11 valid -> WA, speed 0->2->4->6->8->10->11 across successive ctrl=+11? No: tgt=11, so speed steps 1 (from STRAIGHT 1) ->3->5->7->9->11, then holds at 11. With ctrl=+200, speed saturates at 15.
- Hysteresis at defaults: in WA, ctrl=+9 -> stays WA; ctrl=+8 -> W with speed ramping toward 1; from W, ctrl=+10 -> stays W.
- Reversal: in WA at speed 8, ctrl=-40 -> WD with speed 10 (rate-limited toward 15). ctrl_out = -2^31 -> WD with target 15 and no overflow.
- Lost line: 7 updates with line_found=0 -> outputs held and 7 cmd_valid pulses; the 8th -> SEARCH with last_turn and speed toward 3; 60 further lost updates -> HALT, STOP/0; then line_found=1 with ctrl=0 -> TRACK, W, speed 1.
- en=0 during SEARCH with a simultaneous ctrl_valid -> IDLE, STOP/0, no pulse. After re-enable, the first update with line_found=0 -> cmd_valid with STOP/0, still IDLE.
